// File: rtl/avg_pix_filter.sv
// avg_pix_filter: two-stage pipelined 3x3 centre-weighted smoothing kernel.
//   new_color = (8*orig + a+b+c+d+e+f+g+h) >> 4, truncated, never saturated.
// Build option: define AVG_PIX_RGB332_EN to filter each RGB332 channel
// (R=[7:5], G=[4:2], B=[1:0]) independently instead of the whole byte.
// Latency is exactly 2 cycles; new_color holds its last valid value.
module avg_pix_filter #(
  parameter int PIX_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [PIX_W-1:0] a,
  input  logic [PIX_W-1:0] b,
  input  logic [PIX_W-1:0] c,
  input  logic [PIX_W-1:0] d,
  input  logic [PIX_W-1:0] e,
  input  logic [PIX_W-1:0] f,
  input  logic [PIX_W-1:0] g,
  input  logic [PIX_W-1:0] h,
  input  logic [PIX_W-1:0] orig,
  output logic             out_valid,
  output logic [PIX_W-1:0] new_color
);

  logic [PIX_W-1:0] nb [8];
  logic             v1_q;
  logic [PIX_W-1:0] res;

  // Gather the neighbours so the adder tree can be written as a loop
  always_comb begin
    nb = '{a, b, c, d, e, f, g, h};
  end

`ifdef AVG_PIX_RGB332_EN

  // Per-channel accumulators sized for 8*max + 8*max (R/G: 112, B: 48)
  logic [6:0] r_d, r_q;
  logic [6:0] g_d, g_q;
  logic [5:0] b_d, b_q;

  // Stage 1 combinational: weighted sums per channel, no cross-channel carry
  always_comb begin
    r_d = 7'({orig[7:5], 3'b000});
    g_d = 7'({orig[4:2], 3'b000});
    b_d = 6'({orig[1:0], 3'b000});
    for (int unsigned i = 0; i < 8; i++) begin
      r_d = r_d + 7'(nb[i][7:5]);
      g_d = g_d + 7'(nb[i][4:2]);
      b_d = b_d + 6'(nb[i][1:0]);
    end
  end

  // Stage 1 registers: channel sums and valid
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_q <= 1'b0;
      r_q  <= '0;
      g_q  <= '0;
      b_q  <= '0;
    end else begin
      v1_q <= in_valid;
      if (in_valid) begin
        r_q <= r_d;
        g_q <= g_d;
        b_q <= b_d;
      end
    end
  end

  // Divide by 16 per channel and repack
  always_comb begin
    res = {3'(r_q >> 4), 3'(g_q >> 4), 2'(b_q >> 4)};
  end

`else

  // 12-bit accumulator: 8*255 + 8*255 = 4080 fits without overflow
  localparam int ACC_W = PIX_W + 4;

  logic [ACC_W-1:0] acc_d, acc_q;

  // Stage 1 combinational: 8*orig plus the eight neighbours
  always_comb begin
    acc_d = ACC_W'({orig, 3'b000});
    for (int unsigned i = 0; i < 8; i++) begin
      acc_d = acc_d + ACC_W'(nb[i]);
    end
  end

  // Stage 1 registers: weighted sum and valid
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_q  <= 1'b0;
      acc_q <= '0;
    end else begin
      v1_q <= in_valid;
      if (in_valid) begin
        acc_q <= acc_d;
      end
    end
  end

  // Divide by 16, truncating; the quotient always fits in PIX_W bits
  always_comb begin
    res = PIX_W'(acc_q >> 4);
  end

`endif

  // Stage 2 registers: result updates only on valid, so it holds between windows
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      new_color <= '0;
    end else begin
      out_valid <= v1_q;
      if (v1_q) begin
        new_color <= res;
      end
    end
  end

endmodule

// File: tb/tb_avg_pix_filter.sv
// Scoreboard bench for avg_pix_filter: the driver pushes hand-computed
// expectations, a negedge monitor pops and compares each valid output and
// checks the 2-cycle latency. Honours AVG_PIX_RGB332_EN for expected values.
module tb_avg_pix_filter;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [7:0] a, b, c, d, e, f, g, h, orig;
  logic       out_valid;
  logic [7:0] new_color;

  typedef struct {
    logic [7:0]  exp;
    int unsigned cyc;
    string       name;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int unsigned cyc = 0;
  int unsigned run_len = 0;
  int unsigned last_run = 0;

`ifdef AVG_PIX_RGB332_EN
  localparam logic [7:0] EXP_C2    = 8'h9F;
  localparam logic [7:0] EXP_C3    = 8'h3F;
  localparam logic [7:0] EXP_C4B   = 8'h6D;
  localparam logic [7:0] EXP_TRUNC = 8'h01;
`else
  localparam logic [7:0] EXP_C2    = 8'hAF;
  localparam logic [7:0] EXP_C3    = 8'h57;
  localparam logic [7:0] EXP_C4B   = 8'h7F;
  localparam logic [7:0] EXP_TRUNC = 8'h02;
`endif

  avg_pix_filter #(.PIX_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .c         (c),
    .d         (d),
    .e         (e),
    .f         (f),
    .g         (g),
    .h         (h),
    .orig      (orig),
    .out_valid (out_valid),
    .new_color (new_color)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Monitor: compare every valid output against the scoreboard head
  always @(negedge clk) begin
    exp_t x;
    if (!rst && out_valid === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output got %02h, required no output", new_color);
      end else begin
        x = sb.pop_front();
        if (new_color !== x.exp || (cyc - x.cyc) != 2) begin
          errors++;
          $display("FAIL %s got %02h latency %0d, required %02h latency 2",
                   x.name, new_color, cyc - x.cyc, x.exp);
        end
      end
      run_len++;
    end else begin
      if (run_len != 0) last_run = run_len;
      run_len = 0;
    end
  end

  task automatic chk(input string nm, input logic [7:0] got, input logic [7:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s got %02h, required %02h", nm, got, req);
    end
  endtask

  task automatic send(input logic [7:0] ace, input logic [7:0] bdfh,
                      input logic [7:0] o, input logic [7:0] exp, input string nm);
    exp_t x;
    @(posedge clk); #1;
    a = ace; c = ace; e = ace; g = ace;
    b = bdfh; d = bdfh; f = bdfh; h = bdfh;
    orig = o;
    in_valid = 1'b1;
    x.exp = exp; x.cyc = cyc; x.name = nm;
    sb.push_back(x);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      in_valid = 1'b0;
      {a, b, c, d} = $urandom;
      {e, f, g, h} = $urandom;
      orig = 8'($urandom);
    end
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    {a, b, c, d, e, f, g, h, orig} = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_out_valid", {7'b0, out_valid}, 8'h00);
    chk("reset_new_color", new_color, 8'h00);
    rst = 1'b0;
    idle(2);

    // Single windows
    send(8'h00, 8'h00, 8'h00, 8'h00, "case1_zero");            idle(3);
    send(8'h3F, 8'h7F, 8'hFF, EXP_C2, "case2");                idle(3);
    send(8'h1F, 8'h3F, 8'h7F, EXP_C3, "case3");                idle(3);
    chk("single_run_len", 8'(last_run), 8'd1);
    send(8'hFF, 8'hFF, 8'hFF, 8'hFF, "case4_all_ff");          idle(3);
    send(8'h5A, 8'h5A, 8'h5A, 8'h5A, "uniform_5a");            idle(3);
    send(8'h07, 8'h01, 8'h01, EXP_TRUNC, "truncate");          idle(3);
    send(8'hFF, 8'hFF, 8'h00, EXP_C4B, "case4_orig_zero");     idle(4);
    chk("hold_after_valid_drop", new_color, EXP_C4B);
    chk("valid_low_when_idle", {7'b0, out_valid}, 8'h00);

    // Back-to-back windows
    send(8'h00, 8'h00, 8'h00, 8'h00, "b2b_case1");
    send(8'h3F, 8'h7F, 8'hFF, EXP_C2, "b2b_case2");
    send(8'h1F, 8'h3F, 8'h7F, EXP_C3, "b2b_case3");
    idle(4);
    chk("b2b_run_len", 8'(last_run), 8'd3);
    chk("b2b_hold", new_color, EXP_C3);

    // Mid-stream reset: case 2 sits in stage 1 and must be dropped
    send(8'h3F, 8'h7F, 8'hFF, EXP_C2, "reset_victim");
    @(posedge clk); #1;
    in_valid = 1'b0;
    rst = 1'b1;
    sb.delete();
    #1;
    chk("midreset_out_valid", {7'b0, out_valid}, 8'h00);
    chk("midreset_new_color", new_color, 8'h00);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    idle(4);
    chk("post_reset_new_color", new_color, 8'h00);

    // Recovery after reset
    send(8'h1F, 8'h3F, 8'h7F, EXP_C3, "post_reset_case3");
    idle(2);

    // Bounded drain of the scoreboard
    for (int i = 0; i < 10 && sb.size() != 0; i++) @(posedge clk);
    #1;
    chk("scoreboard_drained", 8'(sb.size()), 8'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
